tour_cmd_seq: RTL and testbench
===============================

# tour_cmd_seq

Parametrised tour command sequencer between the UART wrapper, the tour solver and cmd_proc. When idle it passes UART commands straight through to cmd_proc. On `start_tour` it walks a solver move list of `NUM_MOVES` one-hot knight moves and breaks each move into two single-axis commands, vertical and horizontal, in a configurable order. Each command is handed to cmd_proc with a full rdy/clr/resp handshake, and the list may end early on a zero terminator.

## Interface
- `NUM_MOVES`, 24: moves in a full tour (2..31)
- `IDX_W`, 5: width of `mv_indx`; must satisfy 2^IDX_W ≥ NUM_MOVES
- `VERT_FIRST`, 1: 1 = vertical component issued first, 0 = horizontal first
- `clk` in 1: system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `start_tour` in 1: solver done; starts the tour when sampled in IDLE
- `move` in 8: one-hot move at address `mv_indx` (combinational read)
- `mv_indx` out IDX_W: move address
- `cmd_UART` in 16: command from the UART wrapper
- `cmd_rdy_UART` in 1: UART command valid
- `cmd` out 16: muxed command to cmd_proc
- `cmd_rdy` out 1: muxed command valid
- `clr_cmd_rdy` in 1: cmd_proc has consumed the command
- `send_resp` in 1: cmd_proc has completed the command
- `resp` out 8: 8'hA5 = done, 8'h5A = tour in progress
- `tour_busy` out 1: high in every state except IDLE
- `tour_done` out 1: one-cycle pulse when the tour ends normally

## Operation
- States: IDLE, LOAD, FORM_A, WAIT_A, FORM_B, WAIT_B. A is the first axis and B the second, as set by VERT_FIRST.
- IDLE
  - `sel` = UART: `cmd` = `cmd_UART`, `cmd_rdy` = `cmd_rdy_UART`.
  - `start_tour` → clear `mv_indx` and go to LOAD.
- LOAD
  - Register `move` into `move_q`.
  - If `move` == 0 (terminator): go to IDLE and pulse `tour_done`.
  - Otherwise go to FORM_A.
  - If more than one bit is set, only the lowest set bit is used.
- Vertical decode of `move_q`:
  - bit 0/1 → 16'h2002
  - bit 4/5 → 16'h27F2
  - bit 2/7 → 16'h2001
  - bit 3/6 → 16'h27F1
- Horizontal decode of `move_q`:
  - bit 0/4 → 16'h33F1
  - bit 1/5 → 16'h3BF1
  - bit 2/3 → 16'h33F2
  - bit 6/7 → 16'h3BF2
- FORM_x (x = A or B): drive the axis-x command and set the `cmd_rdy_seq` flop. `clr_cmd_rdy` → WAIT_x.
- WAIT_A: hold the axis-A command. `send_resp` → FORM_B.
- WAIT_B: hold the axis-B command. On `send_resp`:
  - if `mv_indx` == NUM_MOVES-1: go to IDLE and pulse `tour_done`;
  - otherwise increment `mv_indx` and go to LOAD.
- `cmd_rdy_seq` is cleared by `clr_cmd_rdy` (clear wins over set) and on every return to IDLE.
- `resp` = 8'hA5 when the state is IDLE, when the state is LOAD with a zero move, or when in WAIT_B with `mv_indx` == NUM_MOVES-1. In all other cases `resp` = 8'h5A.
- `start_tour` is ignored while busy.
- `cmd_UART` and `cmd_rdy_UART` are not forwarded while busy (see Configuration for the abort option).

## Timing
- Reset values:
  - state IDLE
  - `mv_indx` 0, `move_q` 0, `cmd_rdy_seq` 0
  - `cmd_rdy` = `cmd_rdy_UART` (pass-through)
  - `tour_busy` 0, `tour_done` 0
  - `resp` 8'hA5
- Latencies:
  - `start_tour` at edge n → LOAD at n+1.
  - LOAD → FORM_A at n+2.
  - `cmd_rdy` high from edge n+3.
- `cmd_rdy` stays high until the cycle after `clr_cmd_rdy`. `cmd` is stable from FORM_x through WAIT_x.
- `mv_indx` only changes at WAIT_B exit or at tour start, so `move` is stable for LOAD.
- A move with no set bits in a given axis gives `cmd` 16'h0000 (cannot occur with one-hot input).
- Reset mid-tour: immediate return to IDLE with all reset values.

## Configuration
- `TOUR_ABORT_EN` defined:
  - `cmd_rdy_UART` high in any non-IDLE state → IDLE on the next edge.
  - `cmd_rdy_seq` is cleared, `mv_indx` is held, and no `tour_done` pulse is issued.
  - The pending UART command then passes through (its `cmd_rdy_UART` is still high).
- `TOUR_ABORT_EN` undefined: `cmd_rdy_UART` is ignored while busy.

## Test plan
- Idle pass-through: `cmd_UART` 16'h1234 with `cmd_rdy_UART` 1 → `cmd` 16'h1234, `cmd_rdy` 1, `resp` 8'hA5, `tour_busy` 0.
- Single move, VERT_FIRST=1, `move` 8'h01 → 16'h2002 then 16'h33F1, each with `cmd_rdy` held until `clr_cmd_rdy`; `resp` 8'h5A on the vertical command.
- Full tour, NUM_MOVES=24, all moves 8'h40:
  - 48 commands alternating 16'h27F1 and 16'h3BF2;
  - final `resp` 8'hA5;
  - `tour_done` pulse;
  - `mv_indx` ends at 23.
- Terminator: move 3 = 8'h00 → `tour_done` after 3 moves (6 commands); return to IDLE.
- VERT_FIRST=0, `move` 8'h08 → 16'h33F2 then 16'h27F1.
- `TOUR_ABORT_EN`: `cmd_rdy_UART` asserted in WAIT_A → IDLE next cycle, `cmd` = `cmd_UART`, no `tour_done`. Repeat with the macro off → tour continues unaffected.

Source files
------------

// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - knight-tour command sequencer muxing UART and tour commands into cmd_proc
//
// Purpose: while idle, UART commands pass straight through to cmd_proc.
// On start_tour the block walks the solver move list. Each one-hot knight
// move is split into a vertical and a horizontal single-axis command. Both
// commands go to cmd_proc with a rdy/clr/resp handshake. A zero move ends
// the list early.
//
// Parameters:
//   NUM_MOVES   moves in a full tour (2..31)
//   IDX_W       width of mv_indx, 2**IDX_W >= NUM_MOVES
//   VERT_FIRST  1: vertical component first, 0: horizontal first
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_tour        starts a tour when sampled in IDLE
//   move / mv_indx    combinational move-list read (data / address)
//   cmd_UART          command from the UART wrapper
//   cmd_rdy_UART      valid for cmd_UART
//   cmd / cmd_rdy     muxed command and valid toward cmd_proc
//   clr_cmd_rdy       cmd_proc has consumed the command
//   send_resp         cmd_proc has completed the command
//   resp              8'hA5 done, 8'h5A tour in progress
//   tour_busy         high in every state except IDLE
//   tour_done         one-cycle pulse when a tour ends normally
//
// Optional feature: define TOUR_ABORT_EN so that a UART command arriving
// mid-tour aborts the tour and is then passed through.

module tour_cmd_seq #(
    parameter int NUM_MOVES  = 24,
    parameter int IDX_W      = 5,
    parameter bit VERT_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             tour_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FORM_A = 3'd2,
        WAIT_A = 3'd3,
        FORM_B = 3'd4,
        WAIT_B = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  move_q;
    logic        cmd_rdy_seq;
    logic        done_nxt;
    logic        abort;
    logic        last_move;
    logic [15:0] vert_cmd;
    logic [15:0] horiz_cmd;
    logic [15:0] axis_a_cmd;
    logic [15:0] axis_b_cmd;

    // Index of the lowest set bit. A multi-bit move degrades to its lowest bit.
    function automatic logic [2:0] low_bit(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [15:0] decode_vert(input logic [7:0] m);
        logic [15:0] c;
        c = 16'h0000;
        if (m != 8'h00) begin
            case (low_bit(m))
                3'd0, 3'd1: c = 16'h2002;
                3'd4, 3'd5: c = 16'h27F2;
                3'd2, 3'd7: c = 16'h2001;
                default:    c = 16'h27F1;
            endcase
        end
        return c;
    endfunction

    function automatic logic [15:0] decode_horiz(input logic [7:0] m);
        logic [15:0] c;
        c = 16'h0000;
        if (m != 8'h00) begin
            case (low_bit(m))
                3'd0, 3'd4: c = 16'h33F1;
                3'd1, 3'd5: c = 16'h3BF1;
                3'd2, 3'd3: c = 16'h33F2;
                default:    c = 16'h3BF2;
            endcase
        end
        return c;
    endfunction

    assign vert_cmd   = decode_vert(move_q);
    assign horiz_cmd  = decode_horiz(move_q);
    assign axis_a_cmd = VERT_FIRST ? vert_cmd : horiz_cmd;
    assign axis_b_cmd = VERT_FIRST ? horiz_cmd : vert_cmd;
    assign last_move  = (mv_indx == LAST_IDX);

`ifdef TOUR_ABORT_EN
    // A fresh UART command pre-empts the tour. Its valid is still high
    // once the block is back in IDLE, so it passes through untouched.
    assign abort = (state != IDLE) && cmd_rdy_UART;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start_tour) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (move == 8'h00) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = FORM_A;
                end
            end
            FORM_A: begin
                if (clr_cmd_rdy) begin
                    state_nxt = WAIT_A;
                end
            end
            WAIT_A: begin
                if (send_resp) begin
                    state_nxt = FORM_B;
                end
            end
            FORM_B: begin
                if (clr_cmd_rdy) begin
                    state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                if (send_resp) begin
                    if (last_move) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // An aborted tour never reports completion.
        if (abort) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
        end
    end

    // mv_indx moves only at tour start or on WAIT_B exit toward LOAD.
    // This keeps the combinational move read stable through LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_indx <= '0;
        end else if (state == IDLE && state_nxt == LOAD) begin
            mv_indx <= '0;
        end else if (state == WAIT_B && state_nxt == LOAD) begin
            mv_indx <= mv_indx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_q <= 8'h00;
        end else if (state == LOAD) begin
            move_q <= move;
        end
    end

    // Clear has priority over set, so the valid drops the cycle after
    // clr_cmd_rdy even though FORM_x is still the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_rdy_seq <= 1'b0;
        end else if (clr_cmd_rdy || state_nxt == IDLE) begin
            cmd_rdy_seq <= 1'b0;
        end else if (state == FORM_A || state == FORM_B) begin
            cmd_rdy_seq <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tour_done <= 1'b0;
        end else begin
            tour_done <= done_nxt;
        end
    end

    always_comb begin
        cmd     = 16'h0000;
        cmd_rdy = cmd_rdy_seq;
        case (state)
            IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
            end
            FORM_A, WAIT_A: cmd = axis_a_cmd;
            FORM_B, WAIT_B: cmd = axis_b_cmd;
            default:        cmd = 16'h0000;
        endcase
    end

    always_comb begin
        resp = RESP_BUSY;
        if (state == IDLE) begin
            resp = RESP_DONE;
        end else if (state == LOAD && move == 8'h00) begin
            resp = RESP_DONE;
        end else if (state == WAIT_B && last_move) begin
            resp = RESP_DONE;
        end
    end

    assign tour_busy = (state != IDLE);

endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb/tb_tour_cmd_seq.sv - self-checking bench for tour_cmd_seq against a move-list reference model
//
// Unit 0: NUM_MOVES=24, IDX_W=5, VERT_FIRST=1.
// Unit 1: NUM_MOVES=4, IDX_W=2, VERT_FIRST=0.
// Abort expectations follow TOUR_ABORT_EN.

module tb_tour_cmd_seq;

    logic clk;
    logic rst_n;

    logic        start_tour   [2];
    logic        cmd_rdy_uart [2];
    logic        clr          [2];
    logic        send_resp    [2];
    logic [15:0] cmd_uart     [2];
    logic [7:0]  move         [2];

    logic [15:0] cmd0, cmd1;
    logic        cmd_rdy0, cmd_rdy1, busy0, busy1, done0, done1;
    logic [7:0]  resp0, resp1;
    logic [4:0]  mv0;
    logic [1:0]  mv1;

    logic [15:0] cmd       [2];
    logic        cmd_rdy   [2];
    logic        tour_busy [2];
    logic        tour_done [2];
    logic [7:0]  resp      [2];
    logic [4:0]  mv_indx   [2];

    logic [7:0]  mem [2][32];
    int          done_cnt [2] = '{0, 0};
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference tables indexed by the lowest set bit of a move.
    logic [15:0] vtab [8] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                              16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
    logic [15:0] htab [8] = '{16'h33F1, 16'h3BF1, 16'h33F2, 16'h33F2,
                              16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};
    int          nmv  [2] = '{24, 4};
    bit          vf   [2] = '{1'b1, 1'b0};

    tour_cmd_seq #(.NUM_MOVES(24), .IDX_W(5), .VERT_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour[0]), .move(move[0]),
        .mv_indx(mv0), .cmd_UART(cmd_uart[0]), .cmd_rdy_UART(cmd_rdy_uart[0]),
        .cmd(cmd0), .cmd_rdy(cmd_rdy0), .clr_cmd_rdy(clr[0]), .send_resp(send_resp[0]),
        .resp(resp0), .tour_busy(busy0), .tour_done(done0)
    );

    tour_cmd_seq #(.NUM_MOVES(4), .IDX_W(2), .VERT_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour[1]), .move(move[1]),
        .mv_indx(mv1), .cmd_UART(cmd_uart[1]), .cmd_rdy_UART(cmd_rdy_uart[1]),
        .cmd(cmd1), .cmd_rdy(cmd_rdy1), .clr_cmd_rdy(clr[1]), .send_resp(send_resp[1]),
        .resp(resp1), .tour_busy(busy1), .tour_done(done1)
    );

    always_comb begin
        cmd[0] = cmd0;            cmd[1] = cmd1;
        cmd_rdy[0] = cmd_rdy0;    cmd_rdy[1] = cmd_rdy1;
        tour_busy[0] = busy0;     tour_busy[1] = busy1;
        tour_done[0] = done0;     tour_done[1] = done1;
        resp[0] = resp0;          resp[1] = resp1;
        mv_indx[0] = mv0;         mv_indx[1] = {3'b000, mv1};
        move[0] = mem[0][mv0];
        move[1] = mem[1][{3'b000, mv1}];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done0) done_cnt[0] <= done_cnt[0] + 1;
        if (done1) done_cnt[1] <= done_cnt[1] + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rand_move();
        logic [7:0] x;
        if ($urandom_range(0, 3) == 0) begin
            do x = 8'($urandom); while (x == 8'h00);
        end else begin
            x = 8'h01 << $urandom_range(0, 7);
        end
        return x;
    endfunction

    // Runs one tour on unit u, acting as cmd_proc. The expected command
    // list is built from the move list. abort_k selects the command
    // after which a UART command is injected; -1 means no injection.
    task automatic run_tour(input int u, input int abort_k);
        logic [15:0] exp_q[$];
        logic [7:0]  m;
        int          b, last_i, dc0, waitc;
        bit          full;
        full   = 1'b1;
        last_i = nmv[u] - 1;
        for (int i = 0; i < nmv[u]; i++) begin
            m = mem[u][i];
            if (m == 8'h00) begin
                full   = 1'b0;
                last_i = i;
                break;
            end
            b = 0;
            while (!m[b]) b++;
            if (vf[u]) begin
                exp_q.push_back(vtab[b]);
                exp_q.push_back(htab[b]);
            end else begin
                exp_q.push_back(htab[b]);
                exp_q.push_back(vtab[b]);
            end
        end
        dc0 = done_cnt[u];
        start_tour[u] = 1'b1;
        @(negedge clk);
        start_tour[u] = 1'b0;
        check("busy_after_start", 32'(tour_busy[u]), 32'd1);
        for (int k = 0; k < exp_q.size(); k++) begin
            waitc = 0;
            while (!cmd_rdy[u] && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            check("cmd_rdy_seen", 32'(cmd_rdy[u]), 32'd1);
            check("cmd", 32'(cmd[u]), 32'(exp_q[k]));
            check("resp_form", 32'(resp[u]), 32'h5A);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check("rdy_hold", 32'(cmd_rdy[u]), 32'd1);
            clr[u] = 1'b1;
            @(negedge clk);
            clr[u] = 1'b0;
            check("rdy_cleared", 32'(cmd_rdy[u]), 32'd0);
            check("cmd_hold", 32'(cmd[u]), 32'(exp_q[k]));
            if (k == abort_k) begin
                cmd_uart[u]     = 16'($urandom);
                cmd_rdy_uart[u] = 1'b1;
                @(negedge clk);
`ifdef TOUR_ABORT_EN
                check("abort_idle", 32'(tour_busy[u]), 32'd0);
                check("abort_cmd", 32'(cmd[u]), 32'(cmd_uart[u]));
                check("abort_rdy", 32'(cmd_rdy[u]), 32'd1);
                check("abort_idx", 32'(mv_indx[u]), 32'(k / 2));
                cmd_rdy_uart[u] = 1'b0;
                repeat (2) @(negedge clk);
                check("abort_no_done", 32'(done_cnt[u] - dc0), 32'd0);
                return;
`else
                check("ignore_busy", 32'(tour_busy[u]), 32'd1);
                check("ignore_cmd", 32'(cmd[u]), 32'(exp_q[k]));
                check("ignore_rdy", 32'(cmd_rdy[u]), 32'd0);
                cmd_rdy_uart[u] = 1'b0;
`endif
            end
            if (k % 2 == 0) begin
                start_tour[u] = 1'b1;
                @(negedge clk);
                start_tour[u] = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check("resp_wait", 32'(resp[u]),
                  (full && k == exp_q.size() - 1) ? 32'hA5 : 32'h5A);
            send_resp[u] = 1'b1;
            @(negedge clk);
            send_resp[u] = 1'b0;
        end
        waitc = 0;
        while (done_cnt[u] == dc0 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        repeat (2) @(negedge clk);
        check("done_pulses", 32'(done_cnt[u] - dc0), 32'd1);
        check("idle_after", 32'(tour_busy[u]), 32'd0);
        check("resp_idle", 32'(resp[u]), 32'hA5);
        check("mv_indx_end", 32'(mv_indx[u]), 32'(last_i));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_tour[u] = 1'b0; clr[u] = 1'b0; send_resp[u] = 1'b0;
            cmd_uart[u] = 16'h1234; cmd_rdy_uart[u] = 1'b1;
            for (int i = 0; i < 32; i++) mem[u][i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_busy", 32'(tour_busy[u]), 32'd0);
            check("rst_done", 32'(tour_done[u]), 32'd0);
            check("rst_resp", 32'(resp[u]), 32'hA5);
            check("rst_idx", 32'(mv_indx[u]), 32'd0);
            check("rst_rdy_pass", 32'(cmd_rdy[u]), 32'd1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Idle pass-through, first with the literal pattern and then random.
        for (int t = 0; t < 8; t++) begin
            for (int u = 0; u < 2; u++) begin
                cmd_uart[u]     = (t == 0) ? 16'h1234 : 16'($urandom);
                cmd_rdy_uart[u] = (t == 0) ? 1'b1 : 1'($urandom);
            end
            #1;
            for (int u = 0; u < 2; u++) begin
                check("pass_cmd", 32'(cmd[u]), 32'(cmd_uart[u]));
                check("pass_rdy", 32'(cmd_rdy[u]), 32'(cmd_rdy_uart[u]));
                check("pass_resp", 32'(resp[u]), 32'hA5);
                check("pass_busy", 32'(tour_busy[u]), 32'd0);
            end
            @(negedge clk);
        end
        cmd_rdy_uart[0] = 1'b0;
        cmd_rdy_uart[1] = 1'b0;

        // Single move, vertical first.
        mem[0][0] = 8'h01; mem[0][1] = 8'h00;
        run_tour(0, -1);

        // Full tour of 8'h40 moves.
        for (int i = 0; i < 24; i++) mem[0][i] = 8'h40;
        run_tour(0, -1);

        // Terminator at move 3.
        for (int i = 0; i < 24; i++) mem[0][i] = rand_move();
        mem[0][3] = 8'h00;
        run_tour(0, -1);

        // Horizontal first.
        mem[1][0] = 8'h08; mem[1][1] = 8'h00;
        run_tour(1, -1);

        // Empty list.
        mem[1][0] = 8'h00;
        run_tour(1, -1);

        // Random tours with occasional early terminators.
        for (int t = 0; t < 6; t++) begin
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < nmv[u]; i++) mem[u][i] = rand_move();
                if ($urandom_range(0, 2) == 0) mem[u][$urandom_range(1, nmv[u] - 1)] = 8'h00;
                run_tour(u, -1);
            end
        end

        // UART command during WAIT_A of the second move.
        for (int i = 0; i < 24; i++) mem[0][i] = rand_move();
        run_tour(0, 2);
        run_tour(0, -1);

        // Reset in the middle of a tour.
        start_tour[0] = 1'b1;
        @(negedge clk);
        start_tour[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(tour_busy[0]), 32'd0);
        check("midrst_resp", 32'(resp[0]), 32'hA5);
        check("midrst_rdy", 32'(cmd_rdy[0]), 32'd0);
        check("midrst_idx", 32'(mv_indx[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_busy", 32'(tour_busy[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
